// File: rtl/collatz_pkg.sv
// Shared types for the Collatz engine: FSM states and termination reasons.
package collatz_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;
  typedef enum logic [1:0] {R_OK = 2'd0, R_OVF = 2'd1, R_TMO = 2'd2, R_ERR = 2'd3} reason_e;
endpackage

// File: rtl/collatz_engine_if.sv
// Start/result bundle between a seed source (master) and the engine (slave).
interface collatz_engine_if #(parameter int W = 16, parameter int CW = 8);
  logic          start;
  logic          abort;
  logic [W-1:0]  seed;
  logic          busy;
  logic          done;
  logic [W-1:0]  value;
  logic [CW-1:0] steps;
  logic [W-1:0]  peak;
  logic          ovf;
  logic          tmo;
  logic          err;

  modport master (output start, abort, seed,
                  input  busy, done, value, steps, peak, ovf, tmo, err);
  modport slave  (input  start, abort, seed,
                  output busy, done, value, steps, peak, ovf, tmo, err);
endinterface

// File: rtl/collatz_step.sv
// One combinational Collatz step; 3n+1 is formed in W+2 bits so overflow is exact.
module collatz_step #(parameter int W = 16) (
  input  logic [W-1:0] n,
  output logic [W-1:0] next,
  output logic         ovf,
  output logic         is_one,
  output logic         is_zero
);
  logic [W+1:0] n_ext, tn;

  assign n_ext   = {2'b00, n};
  assign tn      = (n_ext << 1) + n_ext + (W+2)'(1);
  assign next    = n[0] ? tn[W-1:0] : {1'b0, n[W-1:1]};
  assign ovf     = n[0] & (|tn[W+1:W]);
  assign is_one  = (n == W'(1));
  assign is_zero = (n == '0);
endmodule

// File: rtl/collatz_engine.sv
// Run-to-completion Collatz engine: one step per clock, tracks steps/peak, flags
// overflow, timeout and zero seed.
module collatz_engine
  import collatz_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = 8
) (
  input  logic clk,
  input  logic rst_n,
  collatz_engine_if.slave bus
);
  localparam logic [1:0]    IDLE     = S_IDLE;
  localparam logic [1:0]    RUN      = S_RUN;
  localparam logic [1:0]    DONE     = S_DONE;
  localparam logic [CW-1:0] STEP_MAX = '1;

  logic [1:0]    state;
  logic [W-1:0]  value, peak, nxt;
  logic [CW-1:0] steps;
  logic          ovf, tmo, err;
  logic          s_ovf, s_one, s_zero;

  collatz_step #(.W(W)) u_step (
    .n(value), .next(nxt), .ovf(s_ovf), .is_one(s_one), .is_zero(s_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      value <= '0;
      peak  <= '0;
      steps <= '0;
      ovf   <= 1'b0;
      tmo   <= 1'b0;
      err   <= 1'b0;
    end else if (bus.abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state <= RUN;
          value <= bus.seed;
          peak  <= bus.seed;
          steps <= '0;
          ovf   <= 1'b0;
          tmo   <= 1'b0;
          err   <= 1'b0;
        end
        // Termination checks are ordered; only the last branch applies a step.
        RUN: begin
          if (s_one) begin
            state <= DONE;
          end else if (s_zero) begin
            err   <= 1'b1;
            state <= DONE;
          end else if (steps == STEP_MAX) begin
            tmo   <= 1'b1;
            state <= DONE;
          end else if (s_ovf) begin
            ovf   <= 1'b1;
            state <= DONE;
          end else begin
            value <= nxt;
            steps <= steps + CW'(1);
            if (nxt > peak) peak <= nxt;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);
  assign bus.value = value;
  assign bus.steps = steps;
  assign bus.peak  = peak;
  assign bus.ovf   = ovf;
  assign bus.tmo   = tmo;
  assign bus.err   = err;
endmodule

// File: tb/tb_collatz_engine.sv
// Directed bench: three engine configurations (W16/CW8, W8/CW8, W16/CW4) sharing one stimulus thread.
`define CHK(tag, obs, exp) begin n_chk++; assert (32'(obs) === 32'(exp)) else begin n_fail++; $error("FAIL %s: observed %0d expected %0d", tag, obs, exp); end end

module tb_collatz_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0;
  logic [15:0] seed = '0;
  int sel = 0;
  int n_chk = 0, n_fail = 0;
  int lat;

  always #5 clk = ~clk;

  collatz_engine_if #(.W(16), .CW(8)) if_a ();
  collatz_engine_if #(.W(8),  .CW(8)) if_b ();
  collatz_engine_if #(.W(16), .CW(4)) if_c ();

  assign if_a.start = start && sel == 0;
  assign if_b.start = start && sel == 1;
  assign if_c.start = start && sel == 2;
  assign if_a.abort = abort && sel == 0;
  assign if_b.abort = abort && sel == 1;
  assign if_c.abort = abort && sel == 2;
  assign if_a.seed  = seed;
  assign if_b.seed  = seed[7:0];
  assign if_c.seed  = seed;

  collatz_engine #(.W(16), .CW(8)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  collatz_engine #(.W(8),  .CW(8)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  collatz_engine #(.W(16), .CW(4)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  logic        o_busy, o_done, o_ovf, o_tmo, o_err;
  logic [15:0] o_value, o_peak;
  logic [7:0]  o_steps;

  always_comb begin
    o_busy = if_a.busy; o_done = if_a.done; o_value = if_a.value; o_peak = if_a.peak;
    o_steps = if_a.steps; o_ovf = if_a.ovf; o_tmo = if_a.tmo; o_err = if_a.err;
    if (sel == 1) begin
      o_busy = if_b.busy; o_done = if_b.done; o_value = {8'h0, if_b.value};
      o_peak = {8'h0, if_b.peak}; o_steps = if_b.steps;
      o_ovf = if_b.ovf; o_tmo = if_b.tmo; o_err = if_b.err;
    end else if (sel == 2) begin
      o_busy = if_c.busy; o_done = if_c.done; o_value = if_c.value; o_peak = if_c.peak;
      o_steps = {4'h0, if_c.steps}; o_ovf = if_c.ovf; o_tmo = if_c.tmo; o_err = if_c.err;
    end
  end

  // Accept a seed, then count edges from the accepting edge to the edge that samples done.
  task automatic run(input int s, input logic [15:0] sd, output int l);
    int k;
    @(negedge clk);
    sel = s; seed = sd; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 1;
    forever begin
      @(negedge clk);
      if (o_done) break;
      if (k > 400) begin
        n_chk++; n_fail++;
        $display("FAIL run_timeout: observed no done after %0d cycles, expected done", k);
        break;
      end
      @(posedge clk);
      k++;
    end
    l = k;
  endtask

  initial begin
    #1;
    `CHK("rst_busy", o_busy, 0)
    `CHK("rst_done", o_done, 0)
    `CHK("rst_value", o_value, 0)
    `CHK("rst_steps", o_steps, 0)
    `CHK("rst_peak", o_peak, 0)
    `CHK("rst_flags", {o_ovf, o_tmo, o_err}, 0)
    @(negedge clk) rst_n = 1'b1;

    run(0, 16'd6, lat);
    `CHK("s6_latency", lat, 10)
    `CHK("s6_value", o_value, 1)
    `CHK("s6_steps", o_steps, 8)
    `CHK("s6_peak", o_peak, 16)
    `CHK("s6_flags", {o_ovf, o_tmo, o_err}, 0)
    @(negedge clk);
    `CHK("s6_idle_busy", o_busy, 0)
    `CHK("s6_idle_done", o_done, 0)
    `CHK("s6_hold_steps", o_steps, 8)

    run(0, 16'd27, lat);
    `CHK("s27_latency", lat, 113)
    `CHK("s27_steps", o_steps, 111)
    `CHK("s27_peak", o_peak, 9232)
    `CHK("s27_value", o_value, 1)
    `CHK("s27_flags", {o_ovf, o_tmo, o_err}, 0)

    run(1, 16'd27, lat);
    `CHK("w8_ovf", o_ovf, 1)
    `CHK("w8_steps", o_steps, 11)
    `CHK("w8_value", o_value, 107)
    `CHK("w8_peak", o_peak, 214)
    `CHK("w8_tmo_err", {o_tmo, o_err}, 0)

    run(1, 16'd1, lat);
    `CHK("w8_s1_latency", lat, 2)
    `CHK("w8_s1_steps", o_steps, 0)
    `CHK("w8_s1_flags", {o_ovf, o_tmo, o_err}, 0)

    run(2, 16'd27, lat);
    `CHK("cw4_tmo", o_tmo, 1)
    `CHK("cw4_steps", o_steps, 15)
    `CHK("cw4_value", o_value, 242)
    `CHK("cw4_peak", o_peak, 484)
    `CHK("cw4_ovf_err", {o_ovf, o_err}, 0)

    run(2, 16'd0, lat);
    `CHK("zero_err", o_err, 1)
    `CHK("zero_steps", o_steps, 0)
    `CHK("zero_latency", lat, 2)

    // Abort during the third RUN cycle of seed 6.
    @(negedge clk);
    sel = 0; seed = 16'd6; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    `CHK("abort_busy", o_busy, 0)
    `CHK("abort_value", o_value, 10)
    `CHK("abort_steps", o_steps, 2)
    repeat (12) begin
      @(negedge clk);
      `CHK("abort_no_done", o_done, 0)
    end

    // Start pulse with a different seed while running must be ignored.
    @(negedge clk);
    sel = 0; seed = 16'd6; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 seed = 16'd27; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    while (!o_done && lat < 50) begin @(negedge clk); lat++; end
    `CHK("ign_done_seen", o_done, 1)
    `CHK("ign_steps", o_steps, 8)
    `CHK("ign_peak", o_peak, 16)
    @(negedge clk);

    // start held high: re-accepted in the IDLE cycle after DONE.
    sel = 1; seed = 16'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    `CHK("b2b_run1", {o_busy, o_done}, 2'b10)
    @(negedge clk);
    `CHK("b2b_done1", o_done, 1)
    @(negedge clk);
    `CHK("b2b_idle", o_busy, 0)
    @(negedge clk);
    `CHK("b2b_rerun", {o_busy, o_done}, 2'b10)
    @(negedge clk);
    `CHK("b2b_done2", o_done, 1)
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-run.
    sel = 0; seed = 16'd27; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    `CHK("arst_busy", o_busy, 0)
    `CHK("arst_done", o_done, 0)
    `CHK("arst_value", o_value, 0)
    `CHK("arst_steps", o_steps, 0)
    `CHK("arst_peak", o_peak, 0)
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    `CHK("arst_stays_idle", o_busy, 0)

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
